// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage sequencer between decoded load/store controls
// and a word-only, handshaked data memory.
//   sw          -> single write
//   sb / sh     -> read-modify-write
//   loads       -> read, then lane select and sign/zero extension
// Misaligned requests raise a one-cycle misalign_err and never reach memory.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a per-phase watchdog forces completion with bus_err after
//   TIMEOUT cycles in RD_REQ, RD_WAIT or WR_REQ. When undefined, waits are
//   unbounded and bus_err is constant 0.
//
// Memory handshake: a request is offered while mem_req=1 and is accepted in
// the cycle where mem_req=1 and mem_gnt=1. While offered but not accepted,
// mem_addr, mem_we and mem_wdata hold steady. Read data returns with
// mem_rvalid=1 at least one cycle after the read grant and is only observed
// in RD_WAIT.
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        MemWriteM,
  input  logic [2:0]        LoadTypeM,
  input  logic [ADDR_W-1:0] AddrM,
  input  logic [31:0]       WriteDataM,
  output logic              stall,
  output logic [31:0]       ReadDataM,
  output logic              done,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_SW  = 3'd0,
    OP_SH  = 3'd1,
    OP_SB  = 3'd2,
    OP_LW  = 3'd3,
    OP_LB  = 3'd4,
    OP_LH  = 3'd5,
    OP_LBU = 3'd6,
    OP_LHU = 3'd7
  } op_t;

  state_t      state, state_n;
  op_t         req_op, op_q;
  logic        is_store, load_valid, req, misaligned, accept;
  logic        busy, tmo, timeout_hit, op_is_load;
  logic [1:0]  lane_q;
  logic [31:0] store_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data, merge_data;

  // Decode the incoming request; a store takes priority over a load.
  always_comb begin
    is_store   = (MemWriteM != 2'b00);
    load_valid = (LoadTypeM >= 3'd1) && (LoadTypeM <= 3'd5);
    req        = is_store || load_valid;
    req_op     = OP_LW;
    if (is_store) begin
      case (MemWriteM)
        2'b01:   req_op = OP_SW;
        2'b10:   req_op = OP_SH;
        default: req_op = OP_SB;
      endcase
    end else begin
      case (LoadTypeM)
        3'd1:    req_op = OP_LW;
        3'd2:    req_op = OP_LB;
        3'd3:    req_op = OP_LH;
        3'd4:    req_op = OP_LBU;
        3'd5:    req_op = OP_LHU;
        default: req_op = OP_LW;
      endcase
    end
    case (req_op)
      OP_SW, OP_LW:          misaligned = (AddrM[1:0] != 2'b00);
      OP_SH, OP_LH, OP_LHU:  misaligned = AddrM[0];
      default:               misaligned = 1'b0;
    endcase
    accept = (state == IDLE) && req && !misaligned;
  end

  assign busy = (state == RD_REQ) || (state == RD_WAIT) || (state == WR_REQ);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt;

  // Watchdog: restarts on every state change, counts cycles spent waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_n != state) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tmo = busy && (cnt >= CNT_W'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; a memory event always wins over the watchdog.
  always_comb begin
    state_n     = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_n = (req_op == OP_SW) ? WR_REQ : RD_REQ;
      end
      RD_REQ: begin
        if (mem_gnt) begin
          state_n = RD_WAIT;
        end else if (tmo) begin
          state_n     = DONE;
          timeout_hit = 1'b1;
        end
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          state_n = op_is_load ? DONE : WR_REQ;
        end else if (tmo) begin
          state_n     = DONE;
          timeout_hit = 1'b1;
        end
      end
      WR_REQ: begin
        if (mem_gnt) begin
          state_n = DONE;
        end else if (tmo) begin
          state_n     = DONE;
          timeout_hit = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pipeline hold: busy states, plus the IDLE cycle of an accepted request.
  assign stall     = busy || accept;
  assign state_dbg = state;

  // Lane selection and extension of the returned word for loads.
  always_comb begin
    op_is_load = (op_q == OP_LW) || (op_q == OP_LB) || (op_q == OP_LH) ||
                 (op_q == OP_LBU) || (op_q == OP_LHU);
    byte_sel   = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel   = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // Merge the narrow store data into the word read back from memory.
  always_comb begin
    merge_data = mem_rdata;
    if (op_q == OP_SB) begin
      merge_data[{lane_q, 3'b000} +: 8] = store_q[7:0];
    end else if (op_q == OP_SH) begin
      if (lane_q[1]) merge_data[31:16] = store_q[15:0];
      else           merge_data[15:0]  = store_q[15:0];
    end
  end

  // Registered memory-side outputs, status pulses and captured request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ReadDataM    <= '0;
      done         <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      op_q         <= OP_LW;
      lane_q       <= 2'b00;
      store_q      <= '0;
    end else begin
      mem_req      <= (state_n == RD_REQ) || (state_n == WR_REQ);
      mem_we       <= (state_n == WR_REQ);
      done         <= (state_n == DONE);
      bus_err      <= timeout_hit;
      misalign_err <= (state == IDLE) && req && misaligned;
      if (accept) begin
        mem_addr <= {AddrM[ADDR_W-1:2], 2'b00};
        op_q     <= req_op;
        lane_q   <= AddrM[1:0];
        store_q  <= WriteDataM;
        if (req_op == OP_SW) mem_wdata <= WriteDataM;
      end
      if ((state == RD_WAIT) && mem_rvalid) begin
        if (op_is_load) ReadDataM <= load_data;
        else            mem_wdata <= merge_data;
      end
      if (timeout_hit) ReadDataM <= '0;
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage sequencer between the pipeline's decoded load/store controls and a word-only, handshaked data memory.
- Runs sw as a single write. Runs sb/sh as read-modify-write and loads as read-then-extend.
- Stalls the pipeline until the access completes and flags misaligned accesses without touching memory.

Parameters:
- ADDR_W, 32, byte-address width; data path fixed at 32 bits.
- TIMEOUT, 255, watchdog limit in cycles per memory phase (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- MemWriteM  input  2  00 none, 01 sw, 10 sh, 11 sb.
- LoadTypeM  input  3  000 none, 001 lw, 010 lb, 011 lh, 100 lbu, 101 lhu; others treated as none.
- AddrM  input  ADDR_W  byte address.
- WriteDataM  input  32  store data; sb uses [7:0], sh uses [15:0].
- stall  output  1  hold pipeline stages up to and including M.
- ReadDataM  output  32  extended load result; valid while done=1.
- done  output  1  one-cycle completion pulse.
- misalign_err  output  1  one-cycle pulse on a misaligned request.
- bus_err  output  1  one-cycle timeout pulse (0 without MEM_TIMEOUT_EN).
- mem_req  output  1  memory request.
- mem_we  output  1  1 write, 0 read.
- mem_addr  output  ADDR_W  word-aligned address; [1:0] always 00.
- mem_wdata  output  32  write word.
- mem_gnt  input  1  request accepted this cycle.
- mem_rvalid  input  1  read data valid; at least 1 cycle after gnt.
- mem_rdata  input  32  read word.

Behaviour:
- Reset (asynchronous): state IDLE. All registered outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, ReadDataM, done, misalign_err, bus_err. Because the reset is asynchronous, mem_req drops immediately, even mid-transaction.
- Request definition: req = MemWriteM!=00 or LoadTypeM is valid. If both a store and a load are present, the store wins and the load is ignored.
- Misalignment:
  - sw/lw with AddrM[1:0]!=0 is misaligned.
  - sh/lh/lhu with AddrM[0]=1 is misaligned.
  - On a misaligned request in IDLE: misalign_err=1 in the next cycle, no mem_req, stall=0, state remains IDLE.
- stall is combinational: 1 in RD_REQ, RD_WAIT and WR_REQ; also 1 in IDLE when an aligned req is present; 0 in DONE.
- IDLE: on an aligned req, capture the address, data and op type.
  - sw goes to WR_REQ, with mem_wdata=WriteDataM.
  - All others go to RD_REQ.
- RD_REQ: mem_req=1, mem_we=0. On mem_gnt, go to RD_WAIT.
- RD_WAIT: mem_req=0. On mem_rvalid:
  - Load: extend per type and lane into ReadDataM, go to DONE.
    - lb/lbu: byte at lane addr[1:0], sign- or zero-extended.
    - lh/lhu: halfword at lane addr[1], sign- or zero-extended.
    - lw: word unchanged.
  - sb/sh: merge into mem_wdata, go to WR_REQ.
    - sb: replace byte lane addr[1:0] with WriteDataM[7:0].
    - sh: replace half lane addr[1] with WriteDataM[15:0].
    - All other bytes keep mem_rdata.
- WR_REQ: mem_req=1, mem_we=1. On mem_gnt, go to DONE.
- DONE: done=1, stall=0 so the pipeline advances. Always returns to IDLE; any req present in DONE is not accepted.
- Hold rule: while mem_req=1 and mem_gnt=0, mem_addr, mem_we and mem_wdata stay constant.
- mem_rvalid outside RD_WAIT is ignored.
- Latency with zero-wait memory (gnt in the first request cycle, rvalid 1 cycle later), counted from request cycle 0:
  - sw: done in cycle 2.
  - Loads: done in cycle 3.
  - sb/sh: done in cycle 4.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro: an 8+ bit counter clears on every state entry and counts cycles in RD_REQ, RD_WAIT and WR_REQ.
  - Reaching TIMEOUT forces DONE with bus_err=1 and done=1, and no write is issued.
  - ReadDataM=0 on a load timeout.
- Without the macro: no counter, bus_err tied to 0, waits are unbounded.

Test Plan:
- sw 0xDEADBEEF to 0x100, gnt immediate -> mem_req/mem_we=1 in cycle 1, mem_addr=0x100, mem_wdata=0xDEADBEEF, stall=1 in cycles 0-1, done in cycle 2.
- sb 0xAB to 0x103, memory word 0x11223344 -> read of 0x100, then write 0xAB223344; sh 0xBEEF to 0x102 on the same word -> write 0xBEEF3344.
- lb from 0x102 with word 0x1180FF22 -> ReadDataM=0xFFFFFF80; lbu -> 0x00000080; lh from 0x100 -> 0xFFFFFF22; lhu from 0x102 -> 0x00001180.
- sw to 0x102, and lh from 0x101 -> misalign_err pulse, mem_req never asserted, stall=0.
- gnt delayed 3 cycles on sw -> address and data held stable, stall held, done 3 cycles later than baseline; assert rst in RD_WAIT -> mem_req/stall=0 immediately, IDLE, later rvalid ignored.
- MEM_TIMEOUT_EN, TIMEOUT=8, gnt never asserted -> bus_err and done in the same cycle after 8 request cycles, no write issued, return to IDLE.
